// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU UART transmitter and its bit timer.
// Optional parity state enabled by ALU_UART_TX_PARITY_EN.
package alu_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;
    localparam int unsigned SIZEDATA_DEFAULT     = 8;
    localparam logic        LINE_IDLE            = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef ALU_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_tick marks the last cycle of a bit.
// pre_tick_c flags that the coming cycle is the last one, for lookahead registering.
module uart_bit_timer
    import alu_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick_c
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign pre_tick_c = (cnt_d == LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q    <= '0;
            bit_tick <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_tick <= pre_tick_c;
        end
    end

endmodule

// File: rtl/alu_uart_tx.sv
// UART 8N1 transmitter for ALU results: latches a byte on TX_START, sends it LSB first.
// Define ALU_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module alu_uart_tx
    import alu_uart_pkg::*;
#(
    parameter int unsigned SIZEDATA     = SIZEDATA_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                TX_START,
    input  logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX,
    output logic                TX_BUSY,
    output logic                TX_DONE
);

    localparam int unsigned IW = (SIZEDATA > 1) ? $clog2(SIZEDATA) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZEDATA - 1);

    state_t              state_q, state_d;
    logic [SIZEDATA-1:0] shift_q, shift_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_tick;
    logic                pre_tick_c;
`ifdef ALU_UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .clear     (state_q == ST_IDLE),
        .bit_tick  (bit_tick),
        .pre_tick_c(pre_tick_c)
    );

    // Next state plus lookahead of the registered line outputs.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef ALU_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (TX_START) begin
                    shift_d = TX_DATA;
                    idx_d   = '0;
                    state_d = ST_START;
`ifdef ALU_UART_TX_PARITY_EN
                    par_d   = ^TX_DATA;
`endif
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
`ifdef ALU_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
`ifdef ALU_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_d = LINE_IDLE;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef ALU_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = LINE_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && pre_tick_c;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TX      = tx_q;
    assign TX_BUSY = busy_q;
    assign TX_DONE = done_q;

endmodule

// File: tb/tb_alu_uart_tx.sv
// Directed scoreboard bench for alu_uart_tx with CLKS_PER_BIT=4, SIZEDATA=8.
// Honours ALU_UART_TX_PARITY_EN to expect the parity bit and longer frame.
module tb_alu_uart_tx;

    localparam int C = 4;
    localparam int N = 8;
`ifdef ALU_UART_TX_PARITY_EN
    localparam int NB = N + 3;
`else
    localparam int NB = N + 2;
`endif
    localparam int L = NB * C;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic       TX;
    logic       TX_BUSY;
    logic       TX_DONE;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    alu_uart_tx #(
        .SIZEDATA    (N),
        .CLKS_PER_BIT(C)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TX_START(TX_START),
        .TX_DATA (TX_DATA),
        .TX      (TX),
        .TX_BUSY (TX_BUSY),
        .TX_DONE (TX_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        TX_START = 1'b1;
        TX_DATA  = d;
        sb.push_back(d);
    endtask

    // Samples one whole frame plus the following cycle, starting at the edge that accepts TX_START.
    task automatic run_frame(input string tag, input bit hold, input int poke_at,
                             input logic [7:0] poke_data);
        logic [7:0]  d;
        logic [63:0] tx_e, busy_e, done_e, tx_o, busy_o, done_o;
        int          bit_no;
        d = 8'h00;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            d = sb.pop_front();
        end
        tx_e = '0; busy_e = '0; done_e = '0;
        tx_o = '0; busy_o = '0; done_o = '0;
        for (int j = 0; j < L; j++) begin
            bit_no    = j / C;
            busy_e[j] = 1'b1;
            done_e[j] = (j == L - 1);
            if (bit_no == 0)           tx_e[j] = 1'b0;
            else if (bit_no <= N)      tx_e[j] = d[bit_no - 1];
            else if (bit_no == N + 1 && NB == N + 3) tx_e[j] = ^d;
            else                       tx_e[j] = 1'b1;
        end
        for (int j = 0; j < L; j++) begin
            @(negedge CLK);
            tx_o[j]   = TX;
            busy_o[j] = TX_BUSY;
            done_o[j] = TX_DONE;
            if (j == 0 && !hold) begin
                TX_START = 1'b0;
                TX_DATA  = ~d;
            end
            if (poke_at >= 0 && j == poke_at) begin
                TX_START = 1'b1;
                TX_DATA  = poke_data;
            end
            if (poke_at >= 0 && j == poke_at + 1) TX_START = 1'b0;
        end
        check({tag, "_tx"},   tx_o,   tx_e);
        check({tag, "_busy"}, busy_o, busy_e);
        check({tag, "_done"}, done_o, done_e);
        @(negedge CLK);
        check({tag, "_after"}, 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        RESET_N  = 1'b0;
        TX_START = 1'b0;
        TX_DATA  = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset", 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
        RESET_N = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            check("idle50", 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
        end

        start_frame(8'hA5);
        run_frame("a5", 1'b0, -1, 8'h00);

        // A second request mid-frame must be dropped, not queued.
        start_frame(8'h3C);
        run_frame("3c", 1'b0, 10, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("noqueue", 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
        end

        start_frame(8'h01);
        sb.push_back(8'h01);
        run_frame("hold1", 1'b1, -1, 8'h00);
        run_frame("hold2", 1'b0, -1, 8'h00);
        repeat (3) @(negedge CLK);
        check("hold_idle", 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Abort a 0x00 frame mid-data with an asynchronous reset.
        TX_START = 1'b1;
        TX_DATA  = 8'h00;
        for (int j = 0; j < 17; j++) begin
            @(negedge CLK);
            if (j == 0) TX_START = 1'b0;
        end
        check("pre_abort", 64'({TX, TX_BUSY}), 64'(2'b01));
        #2 RESET_N = 1'b0;
        #1 check("abort_async", 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_reset", 64'({TX, TX_BUSY, TX_DONE}), 64'(3'b100));
        start_frame(8'h55);
        run_frame("55", 1'b0, -1, 8'h00);

`ifdef ALU_UART_TX_PARITY_EN
        start_frame(8'h07);
        run_frame("par07", 1'b0, -1, 8'h00);
        start_frame(8'h03);
        run_frame("par03", 1'b0, -1, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
